// File: rtl/midi_uart_transmitter.sv
// MIDI OUT serializer: pops bytes from a real-time FIFO and a data FIFO and sends them as 8N1 frames.
// Real-time bytes win arbitration between frames; optional running-status compression of channel status bytes.
module midi_uart_transmitter #(
  parameter int BIT_CLKS       = 8,
  parameter bit RUNNING_STATUS = 1'b0
) (
  input  logic       midi_system_clock,
  input  logic       midi_rst,
  input  logic [7:0] data_fifo_dout,
  input  logic       data_fifo_empty,
  output logic       data_fifo_rd,
  input  logic [7:0] real_fifo_dout,
  input  logic       real_fifo_empty,
  output logic       real_fifo_rd,
  output logic       midi_uart_out,
  output logic       tx_busy
);

  localparam int            CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    last_status_q, last_status_d;
  logic          last_valid_q, last_valid_d;

  logic bit_done;
  logic is_chan_status;
  logic is_sys_common;
  logic rs_drop;

  assign bit_done       = (cnt_q == CNT_LAST);
  assign is_chan_status = data_fifo_dout[7] && (data_fifo_dout[7:4] != 4'hF);
  assign is_sys_common  = (data_fifo_dout[7:3] == 5'b11110);
  // A channel status byte identical to the last one sent is redundant under running status.
  assign rs_drop        = RUNNING_STATUS && is_chan_status && last_valid_q &&
                          (data_fifo_dout == last_status_q);

  always_ff @(posedge midi_system_clock or posedge midi_rst) begin
    if (midi_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      last_status_q <= '0;
      last_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      last_status_q <= last_status_d;
      last_valid_q  <= last_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    last_status_d = last_status_q;
    last_valid_d  = last_valid_q;
    data_fifo_rd  = 1'b0;
    real_fifo_rd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // No pops while reset is held, so no byte is lost during reset.
        if (!midi_rst) begin
          if (!real_fifo_empty) begin
            real_fifo_rd = 1'b1;
            shift_d      = real_fifo_dout;
            state_d      = S_START;
          end else if (!data_fifo_empty) begin
            data_fifo_rd = 1'b1;
            shift_d      = data_fifo_dout;
            if (!rs_drop) begin
              state_d = S_START;
              if (is_chan_status) begin
                last_status_d = data_fifo_dout;
                last_valid_d  = 1'b1;
              end else if (is_sys_common) begin
                last_valid_d  = 1'b0;
              end
            end
          end
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line is decoded from registered state so reset forces it high immediately.
  always_comb begin
    midi_uart_out = 1'b1;
    case (state_q)
      S_START: midi_uart_out = 1'b0;
      S_DATA:  midi_uart_out = shift_q[0];
      default: midi_uart_out = 1'b1;
    endcase
  end

  assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_midi_uart_transmitter.sv
// Bench for midi_uart_transmitter: two instances (running status off/on) fed by queue-modelled FIFOs,
// with a line decoder that rebuilds transmitted bytes from the serial waveform.
module tb_midi_uart_transmitter;
  localparam int B = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] ddout [2];
  logic       dempty [2];
  logic       drd [2];
  logic [7:0] rdout [2];
  logic       rempty [2];
  logic       rrd [2];
  logic       line [2];
  logic       busy [2];

  logic [7:0] dq0[$], dq1[$], rq0[$], rq1[$], rx0[$], rx1[$];
  int         ts0[$], ts1[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         pviol = 0;
  int         drd_cnt [2];
  int         rrd_cnt [2];
  int         fviol [2] = '{0, 0};
  int         fcnt [2];
  logic       infr [2];
  logic       prev [2];
  logic [7:0] sh [2];

  typedef struct packed {
    int          dut;
    int          n;
    logic [63:0] ins;
    int          m;
    logic [63:0] exps;
  } vec_t;

  midi_uart_transmitter #(.BIT_CLKS(B), .RUNNING_STATUS(1'b0)) dut0 (
    .midi_system_clock(clk), .midi_rst(rst),
    .data_fifo_dout(ddout[0]), .data_fifo_empty(dempty[0]), .data_fifo_rd(drd[0]),
    .real_fifo_dout(rdout[0]), .real_fifo_empty(rempty[0]), .real_fifo_rd(rrd[0]),
    .midi_uart_out(line[0]), .tx_busy(busy[0]));

  midi_uart_transmitter #(.BIT_CLKS(B), .RUNNING_STATUS(1'b1)) dut1 (
    .midi_system_clock(clk), .midi_rst(rst),
    .data_fifo_dout(ddout[1]), .data_fifo_empty(dempty[1]), .data_fifo_rd(drd[1]),
    .real_fifo_dout(rdout[1]), .real_fifo_empty(rempty[1]), .real_fifo_rd(rrd[1]),
    .midi_uart_out(line[1]), .tx_busy(busy[1]));

  // FIFO pops and strobe protocol checks, using pre-edge values
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      dq0.delete(); dq1.delete(); rq0.delete(); rq1.delete();
      for (int d = 0; d < 2; d++) begin
        drd_cnt[d] = 0;
        rrd_cnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (drd[d] && rrd[d]) pviol++;
        if ((drd[d] && dempty[d]) || (rrd[d] && rempty[d])) pviol++;
        if ((drd[d] || rrd[d]) && busy[d]) pviol++;
        if (drd[d]) drd_cnt[d]++;
        if (rrd[d]) rrd_cnt[d]++;
      end
      if (drd[0] && dq0.size() > 0) void'(dq0.pop_front());
      if (drd[1] && dq1.size() > 0) void'(dq1.pop_front());
      if (rrd[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (rrd[1] && rq1.size() > 0) void'(rq1.pop_front());
    end
  end

  // FIFO head refresh and serial line decoder (mid-bit sampling)
  always @(negedge clk) begin
    ddout[0]  <= (dq0.size() > 0) ? dq0[0] : 8'h00;
    dempty[0] <= (dq0.size() == 0);
    ddout[1]  <= (dq1.size() > 0) ? dq1[0] : 8'h00;
    dempty[1] <= (dq1.size() == 0);
    rdout[0]  <= (rq0.size() > 0) ? rq0[0] : 8'h00;
    rempty[0] <= (rq0.size() == 0);
    rdout[1]  <= (rq1.size() > 0) ? rq1[0] : 8'h00;
    rempty[1] <= (rq1.size() == 0);
    if (rst) begin
      rx0.delete(); rx1.delete(); ts0.delete(); ts1.delete();
    end
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        infr[d] = 1'b0;
        prev[d] = 1'b1;
        fcnt[d] = 0;
      end else begin
        if (!infr[d] && prev[d] && !line[d]) begin
          infr[d] = 1'b1;
          fcnt[d] = 0;
          if (d == 0) ts0.push_back(cyc); else ts1.push_back(cyc);
        end else if (infr[d]) begin
          fcnt[d]++;
        end
        if (infr[d]) begin
          if (fcnt[d] == B / 2 && line[d]) fviol[d]++;
          for (int k = 0; k < 8; k++)
            if (fcnt[d] == B * (k + 1) + B / 2) sh[d][k] = line[d];
          if (fcnt[d] == 9 * B + B / 2) begin
            if (!line[d]) fviol[d]++;
            if (d == 0) rx0.push_back(sh[d]); else rx1.push_back(sh[d]);
            infr[d] = 1'b0;
          end
        end
        prev[d] = line[d];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
  endtask

  task automatic push_data(input int d, input logic [7:0] b);
    if (d == 0) dq0.push_back(b); else dq1.push_back(b);
  endtask

  task automatic push_real(input int d, input logic [7:0] b);
    if (d == 0) rq0.push_back(b); else rq1.push_back(b);
  endtask

  function automatic int rx_size(input int d);
    return (d == 0) ? rx0.size() : rx1.size();
  endfunction

  function automatic logic [7:0] rx_at(input int d, input int i);
    return (d == 0) ? rx0[i] : rx1[i];
  endfunction

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((dq0.size() + dq1.size() + rq0.size() + rq1.size() > 0 || busy[0] || busy[1]
            || infr[0] || infr[1]) && k < 5000) begin
      step();
      k++;
    end
    step();
    chk(tag, (k >= 5000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Running-status reference: channel status equal to the last sent one is dropped,
  // system common (F0..F7) forgets it, everything else passes untouched.
  function automatic void rs_filter(input logic [7:0] ins[$], output logic [7:0] outs[$]);
    logic       have;
    logic [7:0] last;
    have = 1'b0;
    last = 8'h00;
    outs.delete();
    foreach (ins[i]) begin
      if (ins[i] >= 8'h80 && ins[i] <= 8'hEF) begin
        if (!(have && ins[i] == last)) begin
          outs.push_back(ins[i]);
          have = 1'b1;
          last = ins[i];
        end
      end else begin
        if (ins[i] >= 8'hF0 && ins[i] <= 8'hF7) have = 1'b0;
        outs.push_back(ins[i]);
      end
    end
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vt [6];
    logic [7:0] exp_byte;
    logic [7:0] stream[$], rexp[$], dexp[$], gd[$], gr[$];
    int         errs, lows, nd, nr;

    vt[0] = '{dut: 0, n: 1, ins: 64'h9000000000000000, m: 1, exps: 64'h9000000000000000};
    vt[1] = '{dut: 1, n: 6, ins: 64'h903C40903E400000, m: 5, exps: 64'h903C403E40000000};
    vt[2] = '{dut: 1, n: 8, ins: 64'h903C40F0F7903E40, m: 8, exps: 64'h903C40F0F7903E40};
    vt[3] = '{dut: 0, n: 6, ins: 64'h903C40903E400000, m: 6, exps: 64'h903C40903E400000};
    vt[4] = '{dut: 1, n: 6, ins: 64'h903C803C803C0000, m: 5, exps: 64'h903C803C3C000000};
    vt[5] = '{dut: 1, n: 6, ins: 64'h90F090B0B07F0000, m: 5, exps: 64'h90F090B07F000000};

    // Reset state
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_line%0d", d), line[d], 1'b1);
      chk($sformatf("reset_busy%0d", d), busy[d], 1'b0);
      chk($sformatf("reset_rd%0d", d), {drd[d], rrd[d]}, 2'b00);
    end

    // Exact waveform of a 0x90 frame
    exp_byte = 8'h90;
    push_data(0, exp_byte);
    @(negedge clk); #1;
    chk("t1_rd_strobe", drd[0], 1'b1);
    step();
    for (int s = 0; s < 10; s++) begin
      logic ev;
      errs = 0;
      ev = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : exp_byte[s - 1];
      for (int c = 0; c < B; c++) begin
        if (line[0] !== ev || busy[0] !== 1'b1) errs++;
        step();
      end
      chk($sformatf("t1_slot%0d_errs", s), errs, 0);
    end
    chk("t1_end_line", line[0], 1'b1);
    chk("t1_end_busy", busy[0], 1'b0);
    chk("t1_rd_pulses", drd_cnt[0], 1);

    // Table of byte streams, with and without running status
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int k = 0; k < vt[r].n; k++) push_data(vt[r].dut, vt[r].ins[63 - 8 * k -: 8]);
      wait_drain($sformatf("row%0d_drain", r));
      chk($sformatf("row%0d_count", r), rx_size(vt[r].dut), vt[r].m);
      for (int k = 0; k < vt[r].m; k++)
        chk($sformatf("row%0d_byte%0d", r, k), rx_at(vt[r].dut, k), vt[r].exps[63 - 8 * k -: 8]);
      chk($sformatf("row%0d_rd_pulses", r), drd_cnt[vt[r].dut], vt[r].n);
      $display("row %0d: dut%0d in=%0d bytes, sent=%0d bytes", r, vt[r].dut, vt[r].n, rx_size(vt[r].dut));
    end

    // Simultaneous real-time and data: real-time first, then BIT_CLKS+1 high cycles
    do_reset();
    push_real(0, 8'hF8);
    push_data(0, 8'h3C);
    @(negedge clk); #1;
    chk("t2_real_rd", rrd[0], 1'b1);
    chk("t2_data_rd", drd[0], 1'b0);
    wait_drain("t2_drain");
    chk("t2_count", rx0.size(), 2);
    chk("t2_first", rx_at(0, 0), 8'hF8);
    chk("t2_second", rx_at(0, 1), 8'h3C);
    chk("t2_start_spacing", (ts0.size() == 2) ? ts0[1] - ts0[0] : -1, 10 * B + 1);

    // Real-time byte arriving during bit 3 of a frame overtakes queued data
    do_reset();
    push_data(0, 8'h90);
    push_data(0, 8'h3C);
    errs = 0;
    while (ts0.size() == 0 && errs < 100) begin step(); errs++; end
    chk("t3_frame_start", (ts0.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    while (ts0.size() > 0 && cyc < ts0[0] + 4 * B + 2 && errs < 200) begin step(); errs++; end
    push_real(0, 8'hF8);
    chk("t3_busy_at_push", busy[0], 1'b1);
    wait_drain("t3_drain");
    chk("t3_count", rx0.size(), 3);
    chk("t3_b0", rx_at(0, 0), 8'h90);
    chk("t3_b1", rx_at(0, 1), 8'hF8);
    chk("t3_b2", rx_at(0, 2), 8'h3C);

    // Asynchronous reset in the middle of the data bits
    do_reset();
    push_data(0, 8'h00);
    repeat (30) step();
    chk("t6_line_low_before", line[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6_line_async", line[0], 1'b1);
    chk("t6_busy_async", busy[0], 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 40; c++) begin
      if (line[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
      step();
    end
    chk("t6_idle_after", lows, 0);
    chk("t6_no_rd", drd_cnt[0] + rrd_cnt[0], 0);

    // Randomized mix on both instances against the stream-level model
    do_reset();
    stream.delete();
    rexp.delete();
    nd = 0;
    nr = 0;
    while (nd < 50) begin
      if ($urandom_range(0, 39) == 0) begin
        logic [7:0] b;
        case ($urandom_range(0, 9))
          0, 1:    b = 8'h90;
          2:       b = 8'h80;
          3:       b = 8'hB0;
          4:       b = 8'hE0;
          5:       b = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF7;
          default: b = 8'($urandom_range(0, 127));
        endcase
        stream.push_back(b);
        push_data(0, b);
        push_data(1, b);
        nd++;
      end
      if (nr < 12 && $urandom_range(0, 149) == 0) begin
        logic [7:0] rb;
        rb = 8'($urandom_range(248, 255));
        rexp.push_back(rb);
        push_real(0, rb);
        push_real(1, rb);
        nr++;
      end
      step();
    end
    wait_drain("rand_drain");
    for (int d = 0; d < 2; d++) begin
      if (d == 0) dexp = stream; else rs_filter(stream, dexp);
      gd.delete();
      gr.delete();
      for (int i = 0; i < rx_size(d); i++) begin
        if (rx_at(d, i) >= 8'hF8) gr.push_back(rx_at(d, i)); else gd.push_back(rx_at(d, i));
      end
      chk($sformatf("rand%0d_data_count", d), gd.size(), dexp.size());
      chk($sformatf("rand%0d_real_count", d), gr.size(), rexp.size());
      errs = 0;
      foreach (dexp[i]) if (i >= gd.size() || gd[i] !== dexp[i]) errs++;
      foreach (rexp[i]) if (i >= gr.size() || gr[i] !== rexp[i]) errs++;
      chk($sformatf("rand%0d_seq_errs", d), errs, 0);
      chk($sformatf("rand%0d_data_rd", d), drd_cnt[d], nd);
      chk($sformatf("rand%0d_real_rd", d), rrd_cnt[d], nr);
      $display("random dut%0d: data in=%0d sent=%0d, real in=%0d sent=%0d", d, nd, gd.size(), nr, gr.size());
    end

    chk("protocol_violations", pviol, 0);
    chk("framing_errors", fviol[0] + fviol[1], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
